rotary_value_ctrl: RTL and testbench
====================================

# rotary_value_ctrl

Controller that sits downstream of the quadrature rotary decoder and turns its one-cycle `left`/`right` step pulses and the raw push-button into a bounded setting value. It adds step acceleration for fast spins, selectable saturate/wrap behaviour, synchronous preload, and a debounced one-pulse select strobe. Menu and parameter logic consume `value`, `changed` and `select` directly.

## Interface
- `WIDTH`, 8: bit width of `value`.
- `MIN`, 0: lowest legal value.
- `MAX`, 255: highest legal value. `MIN < MAX < 2**WIDTH`.
- `FAST_WINDOW`, 500000: a step that arrives fewer than this many cycles after the previous step is a fast step.
- `FAST_STEP`, 8: increment used for fast steps. `1 ≤ FAST_STEP ≤ MAX-MIN`.
- `DEBOUNCE`, 50000: number of stable cycles required on the button.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `left` in 1: one-cycle step pulse that decrements the value.
- `right` in 1: one-cycle step pulse that increments the value.
- `press` in 1: raw, asynchronous push-button level (1 = pressed).
- `wrap` in 1: 1 = wrap mode, 0 = saturate mode. Sampled on each step.
- `load` in 1: one-cycle preload request.
- `load_value` in WIDTH: value to preload.
- `value` out WIDTH: current setting.
- `changed` out 1: one-cycle strobe, high when `value` differs from its previous cycle.
- `select` out 1: one-cycle strobe on each debounced press.
- `fast` out 1: high when the last applied step used `FAST_STEP`.

## Operation
- **Reset values:** `value`=MIN, `changed`=0, `select`=0, `fast`=0. The interval counter is set to FAST_WINDOW, so the first step is always slow. The debounce FSM goes to IDLE.
- **Input priority per cycle:** `load` wins over steps.
  - If `left` and `right` are both high in the same cycle, the step is ignored and the interval counter is not reset.
- **Load:** `value` ← `load_value` clamped to [MIN, MAX].
  - The interval counter is left unchanged.
- **Step size:** `FAST_STEP` if the interval counter is below FAST_WINDOW, otherwise 1.
  - Each accepted step clears the interval counter.
  - Otherwise the counter increments every cycle and saturates at FAST_WINDOW.
  - `fast` is updated on every accepted step.
- **Arithmetic:** computed in WIDTH+2 signed bits so that no intermediate result overflows.
- **Saturate mode:** the result is clamped to [MIN, MAX].
- **Wrap mode:** a result above MAX becomes MIN; a result below MIN becomes MAX. There is no modular carry of the overshoot.
- **`changed`:** asserted only if the new value differs from the old. A step at a saturated limit, or a load of the current value, gives `changed`=0.
- **Debounce FSM:** `press` is first passed through a 2-flop synchroniser to give `press_s`. One counter tracks stable cycles.
  - IDLE: `press_s`=1 → PRESS_WAIT, counter cleared.
  - PRESS_WAIT: `press_s`=0 → IDLE. Counter = DEBOUNCE-1 → HELD, and `select` pulses for one cycle.
  - HELD: `press_s`=0 → RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: `press_s`=1 → HELD. Counter = DEBOUNCE-1 → IDLE.
- **Reset mid-operation:** a reset during PRESS_WAIT or HELD never produces a `select`. A button still held when reset releases needs the full DEBOUNCE period before `select` fires.

## Timing
- Step or load in cycle N → new `value` and `changed` visible in cycle N+1. Latency is 1 cycle.
- `changed` and `select` are each exactly one cycle wide.
- `select` fires DEBOUNCE+2 cycles after a clean `press` rising edge (2 synchroniser cycles + DEBOUNCE).
- Back-to-back steps in consecutive cycles are all applied; there is no step loss.
- A step in the cycle immediately after reset is slow.
- Fast/slow boundary: a step exactly FAST_WINDOW cycles after the previous one is slow; one cycle earlier is fast.

## Structure
- Shared package `rotary_pkg` holds:
  - the debounce state typedef (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT);
  - the step-direction encoding constants.
- Sub-module `button_debounce` contains the synchroniser, the FSM and the counter, and outputs the one-cycle `select`.
- Value arithmetic and the interval counter stay in the top module.

## Test plan
- **Saturate at MAX:** reset, `wrap`=0, `load` 254, two `right` pulses 1000 cycles apart → `value`=255 with `changed`=1, then `value`=255 with `changed`=0.
- **Wrap at MIN:** `wrap`=1, `value`=0, one slow `left` → `value`=255 with `changed`=1.
- **Acceleration:** FAST_WINDOW=100. Steps at cycles 0, 50, 200 from `value` 10 → values 11, 19, 20; `fast` = 0, 1, 0.
- **Simultaneous inputs:** `left`+`right` in the same cycle → no change. `load` 77 with `right` in the same cycle → `value`=77.
- **Debounce:** DEBOUNCE=16. `press` bounce of 5 cycles, then held for 40 → exactly one `select`, 18 cycles after the stable edge. Release and re-press after 5 cycles → no second `select`.
- **Reset mid-press:** assert `rst` low during PRESS_WAIT, release it with the button held → `select` comes only DEBOUNCE+2 cycles after reset deassertion; `value`=MIN.

Source files
------------

// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary value controller.
//   deb_state_t : button debounce FSM states
//   DIR_*       : step direction encoding of {left, right}
package rotary_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } deb_state_t;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [1:0] DIR_BOTH = 2'b11;

endpackage

// File: rtl/rotary_value_ctrl_if.sv
// Step/load request and value/strobe result bundle of the rotary value controller.
//   left, right     : one-cycle step pulses (decrement / increment)
//   wrap            : 1 = wrap at the limits, 0 = saturate
//   load, load_value: one-cycle preload request and its value
//   value           : current setting
//   changed, select : one-cycle strobes
//   fast            : last applied step used the fast increment
interface rotary_value_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             left;
  logic             right;
  logic             wrap;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] value;
  logic             changed;
  logic             select;
  logic             fast;

  modport master (
    output left, right, wrap, load, load_value,
    input  value, changed, select, fast
  );

  modport slave (
    input  left, right, wrap, load, load_value,
    output value, changed, select, fast
  );
endinterface

// File: rtl/button_debounce.sv
// Push-button debouncer: 2-flop synchroniser, stable-cycle counter and a
// four-state FSM. Emits a one-cycle select on each debounced press.
//   clk, rst : clock, asynchronous active-low reset
//   press    : raw asynchronous button level (1 = pressed)
//   select   : one-cycle strobe on a debounced press
module button_debounce
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic press,
  output logic select
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [1:0]    sync;
  logic          press_s;
  logic [CW-1:0] cnt;
  logic          cnt_clr;
  deb_state_t    state, state_n;

  assign press_s = sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], press};
      state <= state_n;
      cnt   <= cnt_clr ? '0 : cnt + 1'b1;
    end
  end

  // The counter is held clear in the stable states, so it starts from zero
  // on entry to either wait state.
  always_comb begin
    state_n = state;
    cnt_clr = 1'b0;
    select  = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (press_s) state_n = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!press_s) begin
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_n = HELD;
          select  = 1'b1;
        end
      end
      HELD: begin
        cnt_clr = 1'b1;
        if (!press_s) state_n = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (press_s) state_n = HELD;
        else if (cnt == CNT_LAST) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/rotary_value_ctrl.sv
// Turns decoded rotary step pulses and a raw button into a bounded setting
// value with step acceleration, saturate/wrap limits, preload and a
// debounced select strobe.
//   clk, rst : clock, asynchronous active-low reset
//   press    : raw button level
//   bus      : step/load requests in, value/changed/select/fast out
module rotary_value_ctrl
  import rotary_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int MIN         = 0,
  parameter int MAX         = 255,
  parameter int FAST_WINDOW = 500000,
  parameter int FAST_STEP   = 8,
  parameter int DEBOUNCE    = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                press,
  rotary_value_ctrl_if.slave  bus
);

  localparam int AW = WIDTH + 2;
  typedef logic signed [AW-1:0] arith_t;

  localparam arith_t MIN_A  = arith_t'(MIN);
  localparam arith_t MAX_A  = arith_t'(MAX);
  localparam arith_t FAST_A = arith_t'(FAST_STEP);
  localparam arith_t ONE_A  = arith_t'(1);

  localparam int CW = $clog2(FAST_WINDOW + 1);
  localparam logic [CW-1:0] FW_C = CW'(FAST_WINDOW);
  localparam logic [CW:0]   FW_E = (CW + 1)'(FAST_WINDOW);

  logic [WIDTH-1:0] value_r, value_n;
  logic             changed_r;
  logic             fast_r, fast_n;
  logic [CW-1:0]    icnt, icnt_n;
  logic             fast_step;
  logic             accept;
  arith_t           cur, step_a, res;

  function automatic arith_t clamp(input arith_t x);
    if (x < MIN_A) return MIN_A;
    if (x > MAX_A) return MAX_A;
    return x;
  endfunction

  always_comb begin
    value_n = value_r;
    fast_n  = fast_r;
    icnt_n  = icnt;
    accept  = 1'b0;
    cur     = $signed({2'b00, value_r});
    // icnt restarts at zero the cycle after a step, so icnt+1 is the
    // number of cycles since that step.
    fast_step = ({1'b0, icnt} + 1'b1) < FW_E;
    step_a    = fast_step ? FAST_A : ONE_A;
    res       = cur;

    if (bus.load) begin
      res     = clamp($signed({2'b00, bus.load_value}));
      value_n = res[WIDTH-1:0];
    end else begin
      case ({bus.left, bus.right})
        DIR_UP: begin
          res    = cur + step_a;
          accept = 1'b1;
        end
        DIR_DOWN: begin
          res    = cur - step_a;
          accept = 1'b1;
        end
        DIR_NONE, DIR_BOTH: accept = 1'b0;
        default: accept = 1'b0;
      endcase

      if (accept) begin
        if (bus.wrap) begin
          if (res > MAX_A) res = MIN_A;
          else if (res < MIN_A) res = MAX_A;
        end else begin
          res = clamp(res);
        end
        value_n = res[WIDTH-1:0];
        fast_n  = fast_step;
        icnt_n  = '0;
      end else if (icnt != FW_C) begin
        icnt_n = icnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_r   <= WIDTH'(MIN);
      changed_r <= 1'b0;
      fast_r    <= 1'b0;
      icnt      <= FW_C;
    end else begin
      value_r   <= value_n;
      changed_r <= (value_n != value_r);
      fast_r    <= fast_n;
      icnt      <= icnt_n;
    end
  end

  assign bus.value   = value_r;
  assign bus.changed = changed_r;
  assign bus.fast    = fast_r;

  button_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .press  (press),
    .select (bus.select)
  );

endmodule

// File: tb/tb_rotary_value_ctrl.sv
module tb_rotary_value_ctrl;

  localparam int WIDTH = 8;
  localparam int MIN   = 0;
  localparam int MAX   = 255;
  localparam int FW    = 100;
  localparam int FS    = 8;
  localparam int DB    = 16;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic press = 1'b0;

  rotary_value_ctrl_if #(.WIDTH(WIDTH)) bus ();

  rotary_value_ctrl #(
    .WIDTH      (WIDTH),
    .MIN        (MIN),
    .MAX        (MAX),
    .FAST_WINDOW(FW),
    .FAST_STEP  (FS),
    .DEBOUNCE   (DB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .press (press),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    value;
    int    changed;
    int    fast;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   m_value  = MIN;
  int   m_last   = 0;
  bit   m_has    = 1'b0;
  bit   m_fast   = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int clampi(input int x);
    if (x < MIN) return MIN;
    if (x > MAX) return MAX;
    return x;
  endfunction

  task automatic model_reset();
    m_value = MIN;
    m_has   = 1'b0;
    m_fast  = 1'b0;
    sb_q.delete();
  endtask

  // Drive one cycle of requests, predict the result, compare after the edge.
  task automatic xact(input string tag, input logic l, input logic r,
                      input logic ld, input int lv, input logic w);
    exp_t e;
    int   res;
    int   stp;
    bit   fs;
    bus.left       = l;
    bus.right      = r;
    bus.load       = ld;
    bus.load_value = lv[WIDTH-1:0];
    bus.wrap       = w;
    res = m_value;
    if (ld) begin
      res = clampi(lv);
      if (m_has) m_last++;
    end else if (l != r) begin
      fs  = m_has && ((cyc - m_last) < FW);
      stp = fs ? FS : 1;
      res = r ? m_value + stp : m_value - stp;
      if (w) begin
        if (res > MAX) res = MIN;
        else if (res < MIN) res = MAX;
      end else begin
        res = clampi(res);
      end
      m_fast = fs;
      m_last = cyc;
      m_has  = 1'b1;
    end
    e.tag     = tag;
    e.value   = res;
    e.changed = (res != m_value) ? 1 : 0;
    e.fast    = m_fast ? 1 : 0;
    m_value   = res;
    sb_q.push_back(e);
    tick();
    bus.left  = 1'b0;
    bus.right = 1'b0;
    bus.load  = 1'b0;
    e = sb_q.pop_front();
    check({e.tag, "_value"},   int'(bus.value),   e.value);
    check({e.tag, "_changed"}, int'(bus.changed), e.changed);
    check({e.tag, "_fast"},    int'(bus.fast),    e.fast);
  endtask

  task automatic watch(input int n, output int nsel, output int first);
    nsel  = 0;
    first = -1;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (bus.select) begin
        nsel++;
        if (first < 0) first = k;
      end
    end
  endtask

  initial begin
    int nsel;
    int first;
    bus.left       = 1'b0;
    bus.right      = 1'b0;
    bus.load       = 1'b0;
    bus.load_value = '0;
    bus.wrap       = 1'b0;

    repeat (3) tick();
    check("rst_value",   int'(bus.value),   MIN);
    check("rst_changed", int'(bus.changed), 0);
    check("rst_select",  int'(bus.select),  0);
    check("rst_fast",    int'(bus.fast),    0);
    rst = 1'b1;
    model_reset();

    xact("first_step", 1'b0, 1'b1, 1'b0, 0, 1'b0);
    tick();
    check("changed_width", int'(bus.changed), 0);

    // saturate at MAX
    xact("load254", 1'b0, 1'b0, 1'b1, 254, 1'b0);
    idle(1000);
    xact("sat_r1", 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(1000);
    xact("sat_r2", 1'b0, 1'b1, 1'b0, 0, 1'b0);

    // wrap at both limits
    xact("wrap_max", 1'b0, 1'b1, 1'b0, 0, 1'b1);
    idle(200);
    xact("wrap_min", 1'b1, 1'b0, 1'b0, 0, 1'b1);

    // acceleration and fast/slow boundary
    xact("load10", 1'b0, 1'b0, 1'b1, 10, 1'b0);
    idle(200);
    xact("acc0", 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(49);
    xact("acc50", 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(149);
    xact("acc200", 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(99);
    xact("gap_eq_window", 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(98);
    xact("gap_window_m1", 1'b0, 1'b1, 1'b0, 0, 1'b0);

    // back-to-back steps
    for (int i = 0; i < 3; i++) xact("b2b", 1'b0, 1'b1, 1'b0, 0, 1'b0);

    // fast steps crossing the limits
    xact("load250", 1'b0, 1'b0, 1'b1, 250, 1'b0);
    xact("fast_sat_max", 1'b0, 1'b1, 1'b0, 0, 1'b0);
    xact("load3a", 1'b0, 1'b0, 1'b1, 3, 1'b0);
    xact("fast_wrap_min", 1'b1, 1'b0, 1'b0, 0, 1'b1);
    xact("load3b", 1'b0, 1'b0, 1'b1, 3, 1'b0);
    xact("fast_sat_min", 1'b1, 1'b0, 1'b0, 0, 1'b0);

    // simultaneous inputs
    xact("left_right", 1'b1, 1'b1, 1'b0, 0, 1'b0);
    xact("load_same", 1'b0, 1'b0, 1'b1, int'(m_value), 1'b0);
    xact("load77_right", 1'b0, 1'b1, 1'b1, 77, 1'b0);

    // debounce: bounce, stable press, short release, final release
    for (int i = 0; i < 6; i++) begin
      press = (i % 2 == 0);
      tick();
      check("bounce_no_select", int'(bus.select), 0);
    end
    press = 1'b1;
    watch(40, nsel, first);
    check("press_select_count", nsel, 1);
    check("press_select_latency", first, DB + 2);
    press = 1'b0;
    watch(5, nsel, first);
    check("release_short_select", nsel, 0);
    press = 1'b1;
    watch(40, nsel, first);
    check("repress_select_count", nsel, 0);
    press = 1'b0;
    watch(40, nsel, first);
    check("release_select_count", nsel, 0);

    // reset during PRESS_WAIT with the button still held
    xact("load99", 1'b0, 1'b0, 1'b1, 99, 1'b0);
    press = 1'b1;
    watch(8, nsel, first);
    check("prewait_select_count", nsel, 0);
    #2;
    rst = 1'b0;
    model_reset();
    watch(3, nsel, first);
    check("midrst_select_count", nsel, 0);
    check("midrst_value",   int'(bus.value),   MIN);
    check("midrst_changed", int'(bus.changed), 0);
    check("midrst_fast",    int'(bus.fast),    0);
    rst = 1'b1;
    watch(40, nsel, first);
    check("postrst_select_count", nsel, 1);
    check("postrst_select_latency", first, DB + 2);
    press = 1'b0;
    xact("postrst_step", 1'b0, 1'b1, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
